mem_ctrl: RTL

Memory controller between the core and the single-port, byte-wide unified RAM. It serves two requesters: instruction fetch, which reads whole 64-byte cache blocks, and the load/store buffer (LSB), which reads or writes 1, 2 or 4 bytes. It serialises every access into one byte per cycle on the RAM port and returns each result with a one-cycle done pulse.

---
 rtl/mem_ctrl_pkg.sv | 39 +++
 rtl/mem_ctrl_if.sv | 39 +++
 rtl/mem_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants, state encoding and small helpers for the unified-RAM memory controller.
package mem_ctrl_pkg;

  localparam int ADDR_WID      = 32;
  localparam int DEF_BLK_BYTES = 64;
  localparam int IF_DATA_WID   = 8 * DEF_BLK_BYTES;

  // Memory-mapped IO window: address bits [17:16] == 2'b11
  localparam int         IO_HI  = 17;
  localparam int         IO_LO  = 16;
  localparam logic [1:0] IO_SEL = 2'b11;

  localparam logic [1:0] LEN_1B = 2'd0;
  localparam logic [1:0] LEN_2B = 2'd1;
  localparam logic [1:0] LEN_4B = 2'd2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    IF_READ   = 3'd1,
    LSB_READ  = 3'd2,
    LSB_WRITE = 3'd3,
    DONE      = 3'd4
  } state_t;

  // Encoding 3 is unused by the LSB; it is treated as a word access.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_1B:  return 3'd1;
      LEN_2B:  return 3'd2;
      LEN_4B:  return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io_addr(input logic [ADDR_WID-1:0] a);
    return a[IO_HI:IO_LO] == IO_SEL;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bus bundle between the core requesters, the byte-wide RAM port and mem_ctrl.
interface mem_ctrl_if #(
  parameter int BLK_BYTES = 64
);
  import mem_ctrl_pkg::*;

  // Handshake: if_en / lsb_en are level requests that the requester holds
  // with stable address/length/data until the matching one-cycle done pulse;
  // the done pulse is the only acknowledgement and carries the read data.

  logic [7:0]             mem_din;
  logic [7:0]             mem_dout;
  logic [ADDR_WID-1:0]    mem_a;
  logic                   mem_wr;

  logic                   if_en;
  logic [ADDR_WID-1:0]    if_pc;
  logic                   if_done;
  logic [8*BLK_BYTES-1:0] if_data;

  logic                   lsb_en;
  logic                   lsb_wr;
  logic [ADDR_WID-1:0]    lsb_addr;
  logic [1:0]             lsb_len;
  logic [31:0]            lsb_w_data;
  logic                   lsb_done;
  logic [31:0]            lsb_r_data;

  modport slave (
    input  mem_din, if_en, if_pc, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_w_data,
    output mem_dout, mem_a, mem_wr, if_done, if_data, lsb_done, lsb_r_data
  );

  modport master (
    output mem_din, if_en, if_pc, lsb_en, lsb_wr, lsb_addr, lsb_len, lsb_w_data,
    input  mem_dout, mem_a, mem_wr, if_done, if_data, lsb_done, lsb_r_data
  );

endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: serialises i-fetch block reads and LSB loads/stores onto a byte-wide RAM.
// Optional MEMC_IO_GUARD_EN: stall stores to the IO window while io_buffer_full is high.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int BLK_BYTES = DEF_BLK_BYTES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             io_buffer_full,
  input  logic             rob_clear,
  mem_ctrl_if.slave        bus,
  output state_t           dbg_state
);

  // The counter must reach BLK_BYTES itself, hence one bit more than the slot index.
  localparam int CW = $clog2(BLK_BYTES + 1);
  localparam int SW = $clog2(BLK_BYTES);
  localparam int DW = 8 * BLK_BYTES;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] BLK_CNT = CW'(BLK_BYTES);

  state_t              state, state_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic [CW-1:0]       total, total_d;
  logic [ADDR_WID-1:0] base, base_d;
  logic [31:0]         w_data, w_data_d;

  logic [ADDR_WID-1:0] mem_a_q, mem_a_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                mem_wr_q, mem_wr_d;
  logic                if_done_q, if_done_d;
  logic                lsb_done_q, lsb_done_d;
  logic [DW-1:0]       if_data_q, if_data_d;
  logic [31:0]         lsb_r_data_q, lsb_r_data_d;

  logic [CW-1:0]       cnt_inc;
  logic [SW-1:0]       slot;
  logic [ADDR_WID-1:0] next_addr;
  logic                io_stall;

  assign cnt_inc   = cnt + CNT_ONE;
  assign slot      = SW'(cnt - CNT_ONE);
  assign next_addr = base + ADDR_WID'(cnt_inc);

`ifdef MEMC_IO_GUARD_EN
  assign io_stall = (state == LSB_WRITE) && io_buffer_full && is_io_addr(mem_a_q);
`else
  logic unused_io;
  assign io_stall  = 1'b0;
  assign unused_io = io_buffer_full;
`endif

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    total_d      = total;
    base_d       = base;
    w_data_d     = w_data;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    if_done_d    = if_done_q;
    lsb_done_d   = lsb_done_q;
    if_data_d    = if_data_q;
    lsb_r_data_d = lsb_r_data_q;

    case (state)
      IDLE: begin
        if (bus.lsb_en) begin
          base_d   = bus.lsb_addr;
          total_d  = CW'(len_bytes(bus.lsb_len));
          w_data_d = bus.lsb_w_data;
          mem_a_d  = bus.lsb_addr;
          cnt_d    = '0;
          if (bus.lsb_wr) begin
            state_d    = LSB_WRITE;
            mem_wr_d   = 1'b1;
            mem_dout_d = bus.lsb_w_data[7:0];
          end else begin
            state_d      = LSB_READ;
            lsb_r_data_d = '0;
          end
        end else if (bus.if_en) begin
          base_d  = bus.if_pc;
          total_d = BLK_CNT;
          mem_a_d = bus.if_pc;
          cnt_d   = '0;
          state_d = IF_READ;
        end
      end

      // mem_din lags mem_a by one cycle, so the byte arriving now belongs to slot cnt-1.
      IF_READ, LSB_READ: begin
        if (rob_clear) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_inc;
          mem_a_d = next_addr;
          if (cnt != '0) begin
            if (state == IF_READ) if_data_d[{slot, 3'b000} +: 8] = bus.mem_din;
            else                  lsb_r_data_d[{slot[1:0], 3'b000} +: 8] = bus.mem_din;
          end
          if (cnt == total) begin
            state_d = DONE;
            if (state == IF_READ) if_done_d  = 1'b1;
            else                  lsb_done_d = 1'b1;
          end
        end
      end

      // Stores are already committed, so a flush never interrupts them.
      LSB_WRITE: begin
        if (!io_stall) begin
          cnt_d = cnt_inc;
          if (cnt_inc == total) begin
            state_d    = DONE;
            lsb_done_d = 1'b1;
            mem_wr_d   = 1'b0;
          end else begin
            mem_a_d    = next_addr;
            mem_dout_d = w_data[{cnt_inc[1:0], 3'b000} +: 8];
            mem_wr_d   = 1'b1;
          end
        end
      end

      DONE: begin
        state_d    = IDLE;
        if_done_d  = 1'b0;
        lsb_done_d = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      total        <= '0;
      base         <= '0;
      w_data       <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      if_done_q    <= 1'b0;
      lsb_done_q   <= 1'b0;
      if_data_q    <= '0;
      lsb_r_data_q <= '0;
    end else if (rdy) begin
      state        <= state_d;
      cnt          <= cnt_d;
      total        <= total_d;
      base         <= base_d;
      w_data       <= w_data_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      if_done_q    <= if_done_d;
      lsb_done_q   <= lsb_done_d;
      if_data_q    <= if_data_d;
      lsb_r_data_q <= lsb_r_data_d;
    end
  end

  // The strobe is the only output that must drop immediately when frozen or guarded.
  assign bus.mem_wr     = mem_wr_q & rdy & ~io_stall;
  assign bus.mem_a      = mem_a_q;
  assign bus.mem_dout   = mem_dout_q;
  assign bus.if_done    = if_done_q;
  assign bus.if_data    = if_data_q;
  assign bus.lsb_done   = lsb_done_q;
  assign bus.lsb_r_data = lsb_r_data_q;
  assign dbg_state      = state;

endmodule
